// File: rtl/pixel_write_master.sv
// Single-pixel Avalon-MM write master: takes one draw request at a time, range-checks it,
// issues a 16-bit write with stall timeout, and hands back a one-cycle Write_Finish.
module pixel_write_master #(
   parameter logic [31:0] BASE_ADDR      = 32'h08000000,
   parameter logic [31:0] BUF_BYTES      = 32'h00040000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        Draw,
   input  logic [31:0] Pixel_Address,
   input  logic [15:0] Color,
   output logic        Write_Finish,
   output logic [31:0] m_address,
   output logic        m_write,
   output logic [15:0] m_writedata,
   output logic [1:0]  m_byteenable,
   input  logic        m_waitrequest,
   output logic [31:0] pixel_count,
   output logic [15:0] drop_count,
   output logic        timeout_flag
);

   typedef enum logic [1:0] {StIdle, StWrite, StAck, StHold} state_e;

   // Bounds widened to 33 bits so a buffer ending at 2^32 cannot wrap.
   localparam logic [32:0] LoBound  = {1'b0, BASE_ADDR};
   localparam logic [32:0] HiBound  = {1'b0, BASE_ADDR} + {1'b0, BUF_BYTES};
   localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);

   state_e      r_state;
   state_e      w_state_next;
   logic [31:0] r_addr;
   logic [15:0] r_color;
   logic [15:0] r_wait_cnt;
   logic [31:0] r_pixel_count;
   logic [15:0] r_drop_count;
   logic        r_timeout_flag;

   logic w_in_range;
   logic w_take;
   logic w_accept;
   logic w_timeout;

   assign w_in_range = ({1'b0, Pixel_Address} >= LoBound) &&
                       ({1'b0, Pixel_Address} <  HiBound) &&
                       !Pixel_Address[0];
   assign w_take     = (r_state == StIdle) && Draw;
   assign w_accept   = (r_state == StWrite) && !m_waitrequest;
   assign w_timeout  = (r_state == StWrite) && m_waitrequest && (r_wait_cnt == WaitLast);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (Draw) begin
               w_state_next = w_in_range ? StWrite : StAck;
            end
         end
         StWrite: begin
            if (w_accept || w_timeout) begin
               w_state_next = StAck;
            end
         end
         StAck:   w_state_next = StHold;
         StHold:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs are pure functions of state so reset clears them without waiting for a clock.
   always_comb begin
      m_write      = 1'b0;
      Write_Finish = 1'b0;
      m_address    = 32'h0;
      m_writedata  = 16'h0;
      m_byteenable = 2'b00;
      unique case (r_state)
         StWrite: begin
            m_write      = 1'b1;
            m_address    = r_addr;
            m_writedata  = r_color;
            m_byteenable = 2'b11;
         end
         StAck:   Write_Finish = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addr  <= 32'h0;
         r_color <= 16'h0;
      end else if (w_take) begin
         r_addr  <= Pixel_Address;
         r_color <= Color;
      end
   end

   // Wait counter holds zero outside WRITE, so every WRITE entry starts from a clean count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wait_cnt <= 16'h0;
      end else if (r_state != StWrite) begin
         r_wait_cnt <= 16'h0;
      end else if (m_waitrequest && !w_timeout) begin
         r_wait_cnt <= r_wait_cnt + 16'h1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pixel_count  <= 32'h0;
         r_drop_count   <= 16'h0;
         r_timeout_flag <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pixel_count <= r_pixel_count + 32'h1;
         end
         if (w_take && !w_in_range && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'h1;
         end
         if (w_timeout) begin
            r_timeout_flag <= 1'b1;
         end
      end
   end

   assign pixel_count  = r_pixel_count;
   assign drop_count   = r_drop_count;
   assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_pixel_write_master.sv
// Randomised scoreboard bench for pixel_write_master: driver pushes expected outcomes,
// a negedge monitor plays the Avalon slave and checks every write and finish pulse.
module tb_pixel_write_master;

   localparam logic [31:0] BASE = 32'h08000000;
   localparam logic [31:0] BUF  = 32'h00040000;
   localparam int          TO   = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic        Draw;
   logic [31:0] Pixel_Address;
   logic [15:0] Color;
   logic        Write_Finish;
   logic [31:0] m_address;
   logic        m_write;
   logic [15:0] m_writedata;
   logic [1:0]  m_byteenable;
   logic        m_waitrequest = 1'b0;
   logic [31:0] pixel_count;
   logic [15:0] drop_count;
   logic        timeout_flag;

   pixel_write_master #(
      .BASE_ADDR      (BASE),
      .BUF_BYTES      (BUF),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .Draw          (Draw),
      .Pixel_Address (Pixel_Address),
      .Color         (Color),
      .Write_Finish  (Write_Finish),
      .m_address     (m_address),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_byteenable  (m_byteenable),
      .m_waitrequest (m_waitrequest),
      .pixel_count   (pixel_count),
      .drop_count    (drop_count),
      .timeout_flag  (timeout_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [15:0] c;
      int          stall;
      bit          drop;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          wr_cycles = 0;
   bit          mon_off = 1'b1;
   logic [31:0] m_pix = 0;
   logic [15:0] m_drop = 0;
   logic        m_tf = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
      longint ua = longint'(a);
      return (ua >= longint'(BASE)) && (ua < longint'(BASE) + longint'(BUF)) && (a % 2 == 0);
   endfunction

   // Number of cycles m_write should stay high for a request.
   function automatic int exp_cycles(input bit drop, input int stall);
      if (drop) return 0;
      return (stall >= TO) ? TO : stall + 1;
   endfunction

   // Monitor and slave model: decides waitrequest and checks outputs mid-cycle.
   always @(negedge clk) begin
      if (!mon_off) begin
         if (m_write) begin
            if (exp_q.size() == 0) begin
               chk("write_unexpected", 32'd1, 32'd0);
            end else begin
               chk("m_address", m_address, exp_q[0].a);
               chk("m_writedata", {16'h0, m_writedata}, {16'h0, exp_q[0].c});
               chk("m_byteenable", {30'h0, m_byteenable}, 32'd3);
               chk("write_on_drop", {31'h0, exp_q[0].drop}, 32'd0);
               m_waitrequest = (wr_cycles < exp_q[0].stall);
            end
            wr_cycles++;
         end else begin
            m_waitrequest = 1'($urandom);
         end
         if (Write_Finish) begin
            exp_t e;
            chk("finish_with_write", {31'h0, m_write}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("finish_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("write_cycles", wr_cycles, exp_cycles(e.drop, e.stall));
               if (e.drop) begin
                  if (m_drop != 16'hFFFF) m_drop = m_drop + 16'h1;
               end else if (e.stall >= TO) begin
                  m_tf = 1'b1;
               end else begin
                  m_pix = m_pix + 32'h1;
               end
               chk("pixel_count", pixel_count, m_pix);
               chk("drop_count", {16'h0, drop_count}, {16'h0, m_drop});
               chk("timeout_flag", {31'h0, timeout_flag}, {31'h0, m_tf});
            end
            wr_cycles = 0;
         end
      end
   end

   task automatic scramble();
      Draw          = 1'($urandom);
      Pixel_Address = $urandom;
      Color         = 16'($urandom);
   endtask

   // Call at a negedge while the DUT is in IDLE; the next rising edge samples the request.
   task automatic issue(input logic [31:0] a, input logic [15:0] c, input int s);
      exp_t e;
      Draw          = 1'b1;
      Pixel_Address = a;
      Color         = c;
      e.a = a;
      e.c = c;
      e.stall = s;
      e.drop = !in_range(a);
      exp_q.push_back(e);
   endtask

   task automatic complete(input int exp_lat);
      int n = 0;
      @(negedge clk);
      while (!Write_Finish && n < 40) begin
         scramble();
         @(negedge clk);
         n++;
      end
      chk("finish_latency", n, exp_lat);
      if (!Write_Finish) return;
      scramble();
      @(negedge clk);
      scramble();
      @(negedge clk);
      Draw = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic do_req(input logic [31:0] a, input logic [15:0] c, input int s);
      issue(a, c, s);
      complete(exp_cycles(!in_range(a), s));
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] r = $urandom;
      case ($urandom % 8)
         0: return BASE + {r[17:1], 1'b0};
         1: return BASE + BUF - 32'd2;
         2: return BASE + BUF;
         3: return BASE - 32'd2;
         4: return BASE + {r[17:1], 1'b1};
         5: return {r[31:1], 1'b0};
         6: return BASE;
         default: return BASE + {25'h0, r[5:0], 1'b0};
      endcase
   endfunction

   function automatic int rand_stall();
      if ($urandom % 4 == 0) return $urandom_range(6, 12);
      return $urandom_range(0, 3);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      resetn = 1'b0;
      Draw = 1'b0;
      Pixel_Address = 32'h0;
      Color = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_m_write", {31'h0, m_write}, 32'd0);
      chk("rst_finish", {31'h0, Write_Finish}, 32'd0);
      chk("rst_m_address", m_address, 32'd0);
      chk("rst_m_writedata", {16'h0, m_writedata}, 32'd0);
      chk("rst_m_byteenable", {30'h0, m_byteenable}, 32'd0);
      chk("rst_pixel_count", pixel_count, 32'd0);
      chk("rst_drop_count", {16'h0, drop_count}, 32'd0);
      chk("rst_timeout_flag", {31'h0, timeout_flag}, 32'd0);
      resetn = 1'b1;
      mon_off = 1'b0;
      @(negedge clk);

      do_req(32'h08000010, 16'hF800, 0);
      do_req(32'h08000010, 16'hF800, 5);
      do_req(32'h08040000, 16'h07E0, 0);
      do_req(32'h08000011, 16'h001F, 0);
      do_req(32'h0803FFFE, 16'h1234, TO - 1);
      do_req(32'h08000020, 16'h5678, TO);
      do_req(32'h08000022, 16'h9ABC, 20);
      do_req(32'hFFFFFFFE, 16'h1111, 0);
      do_req(32'h07FFFFFE, 16'h2222, 0);
      for (int i = 0; i < 3; i++) begin
         issue(BASE + 32'(2 * i), 16'(16'hA000 + i), 0);
         complete(1);
      end
      for (int i = 0; i < 150; i++) begin
         do_req(rand_addr(), 16'($urandom), rand_stall());
      end

      // Asynchronous reset in the middle of a stalled write.
      issue(BASE + 32'd4, 16'h1234, 50);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_m_write", {31'h0, m_write}, 32'd1);
      #2;
      mon_off = 1'b1;
      resetn = 1'b0;
      #1;
      chk("arst_m_write", {31'h0, m_write}, 32'd0);
      chk("arst_finish", {31'h0, Write_Finish}, 32'd0);
      chk("arst_m_address", m_address, 32'd0);
      chk("arst_m_writedata", {16'h0, m_writedata}, 32'd0);
      chk("arst_m_byteenable", {30'h0, m_byteenable}, 32'd0);
      chk("arst_pixel_count", pixel_count, 32'd0);
      chk("arst_drop_count", {16'h0, drop_count}, 32'd0);
      chk("arst_timeout_flag", {31'h0, timeout_flag}, 32'd0);
      exp_q.delete();
      wr_cycles = 0;
      m_pix = 0;
      m_drop = 0;
      m_tf = 0;
      @(negedge clk);
      Draw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_finish", {31'h0, Write_Finish}, 32'd0);
         chk("rst_no_write", {31'h0, m_write}, 32'd0);
      end

      // Request already waiting when reset releases is taken on the first edge.
      mon_off = 1'b0;
      issue(BASE + 32'h100, 16'hBEEF, 1);
      resetn = 1'b1;
      complete(2);
      for (int i = 0; i < 20; i++) begin
         do_req(rand_addr(), 16'($urandom), rand_stall());
      end
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
